tensor_assign_engine: RTL and testbench
=======================================

Name: tensor_assign_engine

Overview:
- Write-side engine for a tensor buffer held in an external single-port RAM.
- Executes four element-level store commands on a strided tensor view:
  - SET: scalar write at a multi-dimensional index.
  - SET_NTH: scalar write at a row-major linear element number.
  - FILL: broadcast one value over every element.
  - ASSIGN: copy a streamed tensor of the same shape, element by element.
- Generalises the scalar store path to configurable rank, element width and arbitrary strides (transposed or sliced views).
- Sits between the tensor command decoder and the buffer RAM write port.

Parameters:
- DATA_W, 16, element width in bits
- RANK, 3, number of tensor dimensions
- ADDR_W, 10, RAM word-address width; also the width of each stride and of the base offset
- LOG_W, 4, width of each per-dimension log2 size field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cfg_base  in  ADDR_W  base word offset of the view
- cfg_shape_log2  in  RANK*LOG_W  log2 of each dimension size; dim 0 in the LSBs; dim RANK-1 is fastest-varying
- cfg_stride  in  RANK*ADDR_W  word stride per dimension, same packing as cfg_shape_log2
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  0=SET, 1=SET_NTH, 2=FILL, 3=ASSIGN
- cmd_index  in  RANK*ADDR_W  per-dimension index, used by SET
- cmd_n  in  ADDR_W  linear element number, used by SET_NTH
- cmd_val  in  DATA_W  scalar value for SET, SET_NTH and FILL
- in_valid  in  1  ASSIGN stream beat present
- in_ready  out  1  ASSIGN stream beat accepted
- in_data  in  DATA_W  ASSIGN stream element, row-major order
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when a command is rejected (out of bounds)

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; index counters are cleared.
  - mem_we, mem_addr, mem_wdata, busy, done, err, in_ready are all 0; cmd_ready is 1.
  - Reset mid-command aborts it; no further writes are issued.
- Config latch: cfg_* and cmd_* are sampled on the command handshake (cmd_valid & cmd_ready). Changes while busy have no effect.
- Element count: N = 2^(sum of cfg_shape_log2). All sizes zero gives N = 1.
- Offset: addr = base + sum over i of idx[i]*stride[i], truncated mod 2^ADDR_W. Wrap-around is legal and is not an error.
- Unravel for SET_NTH: idx[RANK-1] = low shape_log2[RANK-1] bits of n, the next dimension takes the next bits, and so on.
- States: IDLE, ISSUE, FILL, ASSIGN.
- IDLE:
  - cmd_ready = 1.
  - On accept, busy rises the next cycle.
  - SET/SET_NTH go to ISSUE.
  - FILL goes to FILL; ASSIGN goes to ASSIGN.
- Bounds check (in IDLE, on accept):
  - SET: reject if any idx[i] >= 2^shape_log2[i].
  - SET_NTH: reject if n >= N.
  - A rejected command pulses err the cycle after accept, issues no write, stays in IDLE, and keeps cmd_ready high.
- ISSUE:
  - One write with mem_we = 1 in the cycle after accept.
  - done pulses in the same cycle.
  - Returns to IDLE; cmd_ready is 1 the following cycle.
- FILL:
  - Row-major odometer, with the last dimension fastest.
  - Element k is written in cycle accept+1+k, one write per cycle, no gaps.
  - done pulses with the write of element N-1; then IDLE.
- ASSIGN:
  - in_ready = 1 throughout ASSIGN and 0 in every other state.
  - Each accepted beat j is written in the cycle after its acceptance, at the offset of element j.
  - in_valid gaps stall the engine with no write.
  - done pulses with the write of beat N-1; in_ready drops in that cycle.
  - in_valid outside ASSIGN is ignored.
- Write pipeline: mem_addr and mem_wdata are registered and hold their last value when mem_we = 0.
- cmd_ready is 0 while busy; back-to-back commands therefore have at least one idle cycle between them.

Test Plan:
- SET: RANK=3, shape_log2={2,2,2}, stride={16,4,1}, base=0x100, idx={1,2,3}, val=0xBEEF -> one write, addr 0x11B, data 0xBEEF, done in the same cycle, err=0.
- SET_NTH with transposed view: shape_log2={1,2,0}, stride={1,2,0}, base=0, n=5 -> unravel idx={1,1,0} -> addr 3; then n=8 -> err pulse, no mem_we.
- FILL: shape_log2={1,1,1}, contiguous strides {4,2,1}, base=0x3FC, val=7 -> 8 consecutive writes to 0x3FC..0x3FF then 0x000..0x003 (wrap), done with the 8th write.
- ASSIGN: 2x2 tensor, strides {1,2} (transpose), data 10,11,12,13 with 2-cycle in_valid gaps -> writes at addresses 0,2,1,3 in data order, no mem_we during gaps, in_ready drops with the last write.
- Reset: assert rst at the 3rd write of a 16-element FILL -> mem_we falls immediately; no writes after reset release; cmd_ready=1 and busy=0.
- Config change: change cfg_stride during FILL -> addresses still follow the latched stride; cmd_valid held during busy is accepted only after done.

Source files
------------

// File: rtl/tensor_assign_engine.sv
// Write-side engine for a strided tensor view held in a single-port RAM.
// Executes SET / SET_NTH / FILL / ASSIGN, emitting one registered write per cycle.
module tensor_assign_engine #(
    parameter int DATA_W = 16,
    parameter int RANK   = 3,
    parameter int ADDR_W = 10,
    parameter int LOG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [RANK*LOG_W-1:0]  cfg_shape_log2,
    input  logic [RANK*ADDR_W-1:0] cfg_stride,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [RANK*ADDR_W-1:0] cmd_index,
    input  logic [ADDR_W-1:0]      cmd_n,
    input  logic [DATA_W-1:0]      cmd_val,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int SUM_W = LOG_W + $clog2(RANK + 1);

    localparam logic [1:0] OP_SET    = 2'd0;
    localparam logic [1:0] OP_NTH    = 2'd1;
    localparam logic [1:0] OP_FILL   = 2'd2;
    localparam logic [1:0] OP_ASSIGN = 2'd3;

    typedef logic [RANK-1:0][ADDR_W-1:0] vec_t;
    typedef logic [RANK-1:0][LOG_W-1:0]  shp_t;

    // ISSUE doubles as the "final write in flight" state for FILL and ASSIGN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FILL   = 2'd2,
        ASSIGN = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] dim_max(input logic [LOG_W-1:0] s);
        logic [ADDR_W-1:0] ones;
        ones = '1;
        return ~(ones << s);
    endfunction

    function automatic logic [ADDR_W-1:0] offset(input logic [ADDR_W-1:0] base,
                                                 input vec_t idx, input vec_t stride);
        logic [ADDR_W-1:0] a;
        a = base;
        for (int i = 0; i < RANK; i++) begin
            a = a + ADDR_W'(idx[i] * stride[i]);
        end
        return a;
    endfunction

    function automatic vec_t odo_next(input vec_t cur, input vec_t mx);
        vec_t nx;
        logic carry;
        nx    = cur;
        carry = 1'b1;
        for (int i = RANK - 1; i >= 0; i--) begin
            if (carry) begin
                if (cur[i] == mx[i]) begin
                    nx[i] = '0;
                end else begin
                    nx[i] = cur[i] + ADDR_W'(1);
                    carry = 1'b0;
                end
            end
        end
        return nx;
    endfunction

    state_t            state, state_nxt;
    vec_t              idx, idx_nxt;
    vec_t              lat_stride, lat_max;
    logic [ADDR_W-1:0] lat_base;
    logic              latch;
    logic              we_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    shp_t              shp_in;
    vec_t              stride_in, index_in, max_in, nth_idx, fill_nx;
    logic [SUM_W-1:0]  shp_sum;
    logic              set_oob, nth_oob;

    assign shp_in    = cfg_shape_log2;
    assign stride_in = cfg_stride;
    assign index_in  = cmd_index;

    // Unravel walks from the fastest dimension, peeling shape_log2 bits off n each step.
    always_comb begin : decode
        logic [SUM_W-1:0] cum;
        cum     = '0;
        set_oob = 1'b0;
        max_in  = '0;
        nth_idx = '0;
        for (int i = RANK - 1; i >= 0; i--) begin
            max_in[i]  = dim_max(shp_in[i]);
            nth_idx[i] = (cmd_n >> cum) & max_in[i];
            if (index_in[i] > max_in[i]) begin
                set_oob = 1'b1;
            end
            cum = cum + SUM_W'(shp_in[i]);
        end
        shp_sum = cum;
    end

    assign nth_oob = ((cmd_n >> shp_sum) != '0);
    assign fill_nx = odo_next(idx, lat_max);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign in_ready  = (state == ASSIGN);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        latch     = 1'b0;
        we_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SET: begin
                            if (set_oob) begin
                                err_nxt = 1'b1;
                            end else begin
                                we_nxt    = 1'b1;
                                done_nxt  = 1'b1;
                                addr_nxt  = offset(cfg_base, index_in, stride_in);
                                wdata_nxt = cmd_val;
                                state_nxt = ISSUE;
                            end
                        end
                        OP_NTH: begin
                            if (nth_oob) begin
                                err_nxt = 1'b1;
                            end else begin
                                we_nxt    = 1'b1;
                                done_nxt  = 1'b1;
                                addr_nxt  = offset(cfg_base, nth_idx, stride_in);
                                wdata_nxt = cmd_val;
                                state_nxt = ISSUE;
                            end
                        end
                        OP_FILL: begin
                            latch     = 1'b1;
                            idx_nxt   = '0;
                            we_nxt    = 1'b1;
                            addr_nxt  = cfg_base;
                            wdata_nxt = cmd_val;
                            if (max_in == '0) begin
                                done_nxt  = 1'b1;
                                state_nxt = ISSUE;
                            end else begin
                                state_nxt = FILL;
                            end
                        end
                        default: begin
                            latch     = 1'b1;
                            idx_nxt   = '0;
                            state_nxt = ASSIGN;
                        end
                    endcase
                end
            end
            ISSUE: begin
                state_nxt = IDLE;
            end
            FILL: begin
                idx_nxt  = fill_nx;
                we_nxt   = 1'b1;
                addr_nxt = offset(lat_base, fill_nx, lat_stride);
                if (fill_nx == lat_max) begin
                    done_nxt  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ASSIGN: begin
                if (in_valid) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = offset(lat_base, idx, lat_stride);
                    wdata_nxt = in_data;
                    if (idx == lat_max) begin
                        done_nxt  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        idx_nxt = fill_nx;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            lat_base   <= '0;
            lat_stride <= '0;
            lat_max    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            if (latch) begin
                lat_base   <= cfg_base;
                lat_stride <= stride_in;
                lat_max    <= max_in;
            end
        end
    end

endmodule

// File: tb/tb_tensor_assign_engine.sv
// Bench for tensor_assign_engine: directed table, corner sequences, random commands vs arithmetic model.
module tb_tensor_assign_engine;

    localparam int DW = 16;
    localparam int RK = 3;
    localparam int AW = 10;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     cfg_base = '0;
    logic [RK*LW-1:0]  cfg_shape_log2 = '0;
    logic [RK*AW-1:0]  cfg_stride = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [RK*AW-1:0]  cmd_index = '0;
    logic [AW-1:0]     cmd_n = '0;
    logic [DW-1:0]     cmd_val = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              busy, done, err;

    int total = 0;
    int bad   = 0;

    tensor_assign_engine #(.DATA_W(DW), .RANK(RK), .ADDR_W(AW), .LOG_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_shape_log2(cfg_shape_log2), .cfg_stride(cfg_stride),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cmd_n(cmd_n), .cmd_val(cmd_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int               op;
        logic [AW-1:0]    base;
        logic [RK*LW-1:0] shp;
        logic [RK*AW-1:0] str;
        logic [RK*AW-1:0] idx;
        logic [AW-1:0]    n;
        logic [DW-1:0]    val;
        int               exp_addr;
        bit               exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: element k of the row-major view, by division over dimension sizes.
    function automatic int ref_elem_addr(int k, logic [AW-1:0] base,
                                         logic [RK*LW-1:0] shp, logic [RK*AW-1:0] str);
        int rem, a, sz;
        rem = k;
        a   = int'(base);
        for (int d = RK - 1; d >= 0; d--) begin
            sz  = 1 << int'(shp[d*LW +: LW]);
            a   = a + (rem % sz) * int'(str[d*AW +: AW]);
            rem = rem / sz;
        end
        return a % (1 << AW);
    endfunction

    function automatic int ref_count(logic [RK*LW-1:0] shp);
        int s;
        s = 0;
        for (int d = 0; d < RK; d++) s = s + int'(shp[d*LW +: LW]);
        return 1 << s;
    endfunction

    task automatic issue(input int op, input logic [AW-1:0] base, input logic [RK*LW-1:0] shp,
                         input logic [RK*AW-1:0] str, input logic [RK*AW-1:0] idx,
                         input logic [AW-1:0] n, input logic [DW-1:0] val);
        @(posedge clk); #1;
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cfg_base       = base;
        cfg_shape_log2 = shp;
        cfg_stride     = str;
        cmd_op         = 2'(op);
        cmd_index      = idx;
        cmd_n          = n;
        cmd_val        = val;
        in_valid       = (op != 3) ? 1'($urandom_range(1, 0)) : 1'b0;
        in_data        = DW'($urandom);
        cmd_valid      = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic scalar_cmd(input int op, input logic [AW-1:0] base, input logic [RK*LW-1:0] shp,
                              input logic [RK*AW-1:0] str, input logic [RK*AW-1:0] idx,
                              input logic [AW-1:0] n, input logic [DW-1:0] val,
                              input int exp_addr, input bit exp_err);
        issue(op, base, shp, str, idx, n, val);
        @(negedge clk);
        chk("scalar_err", err, int'(exp_err));
        chk("scalar_we", mem_we, int'(!exp_err));
        chk("scalar_done", done, int'(!exp_err));
        chk("scalar_busy", busy, int'(!exp_err));
        chk("scalar_in_ready", in_ready, 0);
        if (!exp_err) begin
            chk("scalar_addr", mem_addr, exp_addr);
            chk("scalar_data", mem_wdata, val);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("scalar_after_we", mem_we, 0);
        chk("scalar_after_pulses", {done, err}, 0);
        chk("scalar_after_ready", cmd_ready, 1);
        if (!exp_err) chk("scalar_addr_hold", mem_addr, exp_addr);
        in_valid = 1'b0;
    endtask

    task automatic fill_cmd(input logic [AW-1:0] base, input logic [RK*LW-1:0] shp,
                            input logic [RK*AW-1:0] str, input logic [DW-1:0] val, input bit hold_set);
        int n;
        n = ref_count(shp);
        issue(2, base, shp, str, '0, '0, val);
        if (hold_set) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'd0;
            cmd_index = '0;
            cmd_val   = 16'h55AA;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("fill_we", mem_we, 1);
            chk("fill_addr", mem_addr, ref_elem_addr(k, base, shp, str));
            chk("fill_data", mem_wdata, val);
            chk("fill_done", done, int'(k == n - 1));
            chk("fill_ready", cmd_ready, 0);
            @(posedge clk); #1;
            cfg_stride     = RK*AW'($urandom);
            cfg_shape_log2 = RK*LW'($urandom);
        end
        @(negedge clk);
        chk("fill_after_we", mem_we, 0);
        chk("fill_after_ready", cmd_ready, 1);
        chk("fill_after_busy", busy, 0);
        chk("fill_addr_hold", mem_addr, ref_elem_addr(n - 1, base, shp, str));
        if (hold_set) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("held_set_we", mem_we, 1);
            chk("held_set_addr", mem_addr, base);
            chk("held_set_data", mem_wdata, 16'h55AA);
            chk("held_set_done", done, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic assign_cmd(input logic [AW-1:0] base, input logic [RK*LW-1:0] shp,
                              input logic [RK*AW-1:0] str, input int gmin, input int gmax);
        int n, j, pj, gap, budget;
        int dq[$];
        bit pend, fin, v;
        n = ref_count(shp);
        for (int k = 0; k < n; k++) dq.push_back(int'($urandom_range(16'hFFFF, 0)));
        issue(3, base, shp, str, '0, '0, '0);
        j = 0; pj = 0; pend = 0; fin = 0;
        gap    = int'($urandom_range(gmax, gmin));
        budget = n * (gmax + 2) + 8;
        while (!fin && budget > 0) begin
            budget--;
            v        = (j < n) && (gap == 0);
            in_valid = v;
            in_data  = (j < n) ? DW'(dq[j]) : DW'($urandom);
            if (j < n && gap > 0) gap--;
            @(negedge clk);
            chk("asg_we", mem_we, int'(pend));
            chk("asg_in_ready", in_ready, int'(j < n));
            chk("asg_busy", busy, 1);
            if (pend) begin
                chk("asg_addr", mem_addr, ref_elem_addr(pj, base, shp, str));
                chk("asg_data", mem_wdata, dq[pj]);
                chk("asg_done", done, int'(pj == n - 1));
                if (pj == n - 1) fin = 1;
            end
            @(posedge clk); #1;
            if (v) begin
                pend = 1; pj = j; j++;
                gap = int'($urandom_range(gmax, gmin));
            end else begin
                pend = 0;
            end
        end
        if (!fin) chk("asg_timeout", 0, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("asg_after_we", mem_we, 0);
        chk("asg_after_ready", cmd_ready, 1);
        chk("asg_after_in_ready", in_ready, 0);
    endtask

    task automatic set_vec(input int i, input int op, input logic [AW-1:0] base,
                           input logic [RK*LW-1:0] shp, input logic [RK*AW-1:0] str,
                           input logic [RK*AW-1:0] idx, input logic [AW-1:0] n,
                           input logic [DW-1:0] val, input int ea, input bit ee);
        tbl[i].op = op; tbl[i].base = base; tbl[i].shp = shp; tbl[i].str = str;
        tbl[i].idx = idx; tbl[i].n = n; tbl[i].val = val;
        tbl[i].exp_addr = ea; tbl[i].exp_err = ee;
    endtask

    initial begin
        logic [RK*LW-1:0] shp;
        logic [RK*AW-1:0] str, idx;
        logic [AW-1:0]    base, n;
        int               cnt, op, ea, sz;
        bit               ee;

        // Packed fields read right-to-left: dim 0 is the rightmost element.
        set_vec(0, 0, 10'h100, {4'd2, 4'd2, 4'd2}, {10'd1, 10'd4, 10'd16}, {10'd3, 10'd2, 10'd1},
                '0, 16'hBEEF, 'h11B, 0);
        set_vec(1, 1, 10'h000, {4'd0, 4'd2, 4'd1}, {10'd0, 10'd2, 10'd1}, '0, 10'd5, 16'h1234, 3, 0);
        set_vec(2, 1, 10'h000, {4'd0, 4'd2, 4'd1}, {10'd0, 10'd2, 10'd1}, '0, 10'd8, 16'h1234, 0, 1);
        set_vec(3, 0, 10'h100, {4'd2, 4'd2, 4'd2}, {10'd1, 10'd4, 10'd16}, {10'd0, 10'd4, 10'd0},
                '0, 16'h0001, 0, 1);
        set_vec(4, 0, 10'h3FF, {4'd0, 4'd0, 4'd1}, {10'd0, 10'd0, 10'd2}, {10'd0, 10'd0, 10'd1},
                '0, 16'hA5A5, 1, 0);
        set_vec(5, 1, 10'h02A, '0, '0, '0, 10'd0, 16'h0077, 'h2A, 0);
        set_vec(6, 1, 10'h02A, '0, '0, '0, 10'd1, 16'h0077, 0, 1);
        set_vec(7, 0, 10'h000, {4'd0, 4'd0, 4'd3}, {10'd0, 10'd0, 10'd5}, {10'd0, 10'd0, 10'd7},
                '0, 16'hFFFF, 35, 0);

        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, err}, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            scalar_cmd(tbl[i].op, tbl[i].base, tbl[i].shp, tbl[i].str, tbl[i].idx, tbl[i].n,
                       tbl[i].val, tbl[i].exp_addr, tbl[i].exp_err);
        end

        // Wrapping fill, then a 2x2 transposed assign with fixed two-cycle gaps.
        fill_cmd(10'h3FC, {4'd1, 4'd1, 4'd1}, {10'd1, 10'd2, 10'd4}, 16'd7, 1'b0);
        assign_cmd(10'h000, {4'd0, 4'd1, 4'd1}, {10'd0, 10'd2, 10'd1}, 2, 2);
        fill_cmd(10'h010, '0, '0, 16'h0BAD, 1'b0);
        // Command held during a fill must only be taken after done.
        fill_cmd(10'h040, {4'd0, 4'd1, 4'd2}, {10'd3, 10'd9, 10'd1}, 16'h1357, 1'b1);

        // Reset on the third write of a 16-element fill.
        shp = {4'd2, 4'd2, 4'd0};
        str = {10'd1, 10'd4, 10'd0};
        issue(2, 10'h020, shp, str, '0, '0, 16'hC0DE);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstfill_we", mem_we, 1);
            chk("rstfill_addr", mem_addr, ref_elem_addr(k, 10'h020, shp, str));
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        #1 rst = 1'b1;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we) cnt++;
        end
        chk("postrst_writes", cnt, 0);
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_busy", busy, 0);

        for (int it = 0; it < 30; it++) begin
            op   = int'($urandom_range(3, 0));
            base = AW'($urandom);
            str  = RK*AW'($urandom);
            shp  = '0;
            idx  = '0;
            ee   = 0;
            ea   = int'(base);
            for (int d = 0; d < RK; d++) begin
                shp[d*LW +: LW] = LW'($urandom_range(2, 0));
                sz = 1 << int'(shp[d*LW +: LW]);
                idx[d*AW +: AW] = AW'($urandom_range(sz, 0));
                if (int'(idx[d*AW +: AW]) >= sz) ee = 1;
                ea = ea + int'(idx[d*AW +: AW]) * int'(str[d*AW +: AW]);
            end
            ea = ea % (1 << AW);
            case (op)
                0: scalar_cmd(0, base, shp, str, idx, '0, DW'($urandom), ea, ee);
                1: begin
                    n  = AW'($urandom_range(ref_count(shp) + 2, 0));
                    ee = (int'(n) >= ref_count(shp));
                    scalar_cmd(1, base, shp, str, '0, n, DW'($urandom),
                               ee ? 0 : ref_elem_addr(int'(n), base, shp, str), ee);
                end
                2: fill_cmd(base, shp, str, DW'($urandom), 1'($urandom_range(1, 0)));
                default: assign_cmd(base, shp, str, 0, 2);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
